// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: memory access size codes, MEM stage FSM
// encoding, and the register bundles used by the MEM stage.
package mips_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10,
    MEM_X = 2'b11
  } mem_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Data-memory bus drive, held steady for the whole access.
  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } dmem_bus_t;

  // Operands and control presented to the MEM/WB register.
  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] alu_data;
    logic [4:0]  wreg;
    logic        regw;
    logic        m2r;
    logic        le;
  } wb_out_t;

  // Instruction fields captured while a bus access is outstanding.
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [4:0]  wreg;
    logic        regw;
    logic        m2r;
  } mem_cap_t;

  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                               input logic [1:0] off);
    case (size)
      MEM_B:   lane_enables = 4'b0001 << off;
      MEM_H:   lane_enables = off[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  // Stores replicate the datum across every lane; byte enables pick the target.
  function automatic logic [31:0] store_lanes(input logic [1:0]  size,
                                              input logic [31:0] data);
    case (size)
      MEM_B:   store_lanes = {4{data[7:0]}};
      MEM_H:   store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the addressed byte/half lane of a read word
// and sign- or zero-extends it to 32 bits.
module mem_load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o    = rdata_i;
    case (size_i)
      MEM_B:   data_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
      MEM_H:   data_o = {{16{signed_i & half_lane[15]}}, half_lane};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM pipeline stage: issues byte/half/word loads and stores on a
// req/ack data bus, stalls upstream while busy and reports bad accesses.
module mem_access_stage
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] StoreDataIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        RegWriteIn,
  input  logic        MemtoRegIn,
  input  logic [1:0]  MemSizeIn,
  input  logic        MemSignedIn,
  input  logic [4:0]  WriteRegIn,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] MemDataOut,
  output logic [31:0] ALUDataOut,
  output logic [4:0]  WriteRegOut,
  output logic        RegWriteOut,
  output logic        MemtoRegOut,
  output logic        wb_le,
  output logic        stall,
  output logic        mem_fault,
  output logic [31:0] fault_addr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  dmem_bus_t        bus_q, bus_d;
  wb_out_t          wb_q, wb_d;
  mem_cap_t         cap_q, cap_d;
  logic             mem_fault_q, mem_fault_d;
  logic [31:0]      fault_addr_q, fault_addr_d;

  logic             is_memop;
  logic             bad_access;
  logic             issue;
  logic [31:0]      load_data;

  mem_load_align u_load_align (
    .rdata_i   (dmem_rdata),
    .addr_lo_i (cap_q.addr[1:0]),
    .size_i    (cap_q.size),
    .signed_i  (cap_q.sgn),
    .data_o    (load_data)
  );

  assign is_memop   = MemReadIn | MemWriteIn;
  assign bad_access = (MemReadIn & MemWriteIn)
                    | (MemSizeIn == MEM_X)
                    | ((MemSizeIn == MEM_H) & ALUResultIn[0])
                    | ((MemSizeIn == MEM_W) & (|ALUResultIn[1:0]));
  assign issue      = ex_valid & is_memop & ~bad_access;
  assign cnt_inc    = cnt_q + 1'b1;

  // Upstream must freeze in the issue cycle and every WAIT cycle lacking ack.
  assign stall = ((state_q == ST_IDLE) & issue)
               | ((state_q == ST_WAIT) & ~dmem_ack);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_d        = bus_q;
    wb_d         = wb_q;
    wb_d.le      = 1'b0;
    cap_d        = cap_q;
    mem_fault_d  = 1'b0;
    fault_addr_d = fault_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (!ex_valid) begin
          wb_d.le   = 1'b1;
          wb_d.regw = 1'b0;
        end else if (!is_memop || bad_access) begin
          wb_d.mem_data = '0;
          wb_d.alu_data = ALUResultIn;
          wb_d.wreg     = WriteRegIn;
          wb_d.regw     = RegWriteIn & ~is_memop;
          wb_d.m2r      = MemtoRegIn;
          wb_d.le       = 1'b1;
          if (is_memop) begin
            mem_fault_d  = 1'b1;
            fault_addr_d = ALUResultIn;
          end
        end else begin
          state_d    = ST_WAIT;
          cnt_d      = '0;
          cap_d      = '{addr: ALUResultIn, size: MemSizeIn, sgn: MemSignedIn,
                         wreg: WriteRegIn, regw: RegWriteIn, m2r: MemtoRegIn};
          bus_d.req   = 1'b1;
          bus_d.we    = MemWriteIn;
          bus_d.addr  = {ALUResultIn[31:2], 2'b00};
          bus_d.be    = lane_enables(MemSizeIn, ALUResultIn[1:0]);
          bus_d.wdata = store_lanes(MemSizeIn, StoreDataIn);
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_inc;
        if (dmem_ack) begin
          state_d       = ST_IDLE;
          bus_d.req     = 1'b0;
          wb_d.mem_data = bus_q.we ? '0 : load_data;
          wb_d.alu_data = cap_q.addr;
          wb_d.wreg     = cap_q.wreg;
          wb_d.regw     = cap_q.regw;
          wb_d.m2r      = cap_q.m2r;
          wb_d.le       = 1'b1;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d       = ST_IDLE;
          bus_d.req     = 1'b0;
          wb_d.mem_data = '0;
          wb_d.alu_data = cap_q.addr;
          wb_d.wreg     = cap_q.wreg;
          wb_d.regw     = 1'b0;
          wb_d.m2r      = cap_q.m2r;
          wb_d.le       = 1'b1;
          mem_fault_d   = 1'b1;
          fault_addr_d  = cap_q.addr;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bus_q        <= '0;
      wb_q         <= '0;
      cap_q        <= '0;
      mem_fault_q  <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_q        <= bus_d;
      wb_q         <= wb_d;
      cap_q        <= cap_d;
      mem_fault_q  <= mem_fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign dmem_req    = bus_q.req;
  assign dmem_we     = bus_q.we;
  assign dmem_addr   = bus_q.addr;
  assign dmem_be     = bus_q.be;
  assign dmem_wdata  = bus_q.wdata;
  assign MemDataOut  = wb_q.mem_data;
  assign ALUDataOut  = wb_q.alu_data;
  assign WriteRegOut = wb_q.wreg;
  assign RegWriteOut = wb_q.regw;
  assign MemtoRegOut = wb_q.m2r;
  assign wb_le       = wb_q.le;
  assign mem_fault   = mem_fault_q;
  assign fault_addr  = fault_addr_q;

endmodule
